// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared geometry, result/tag types and constants for the divider wrapper
package divider_pkg;

  localparam int DIV_N     = 5;
  localparam int DIV_M     = 3;
  localparam int DIV_DEPTH = 8;

  localparam logic [DIV_N-1:0] DBZ_QUOTIENT = '1;

  typedef struct packed {
    logic [DIV_N-1:0] quotient;
    logic [DIV_M-1:0] remainder;
    logic             dbz;
  } div_result_t;

  typedef struct packed {
    logic valid;
    logic dbz;
  } div_tag_t;

  // The restoring core has one register stage per quotient bit.
  function automatic int div_lat(input int n);
    return n;
  endfunction

endpackage

// File: rtl/divider_result_fifo.sv
// rtl/divider_result_fifo.sv - synchronous result FIFO with occupancy count
// Writers must respect the count; there is no full guard on the write side.
module divider_result_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("divider_result_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;

  assign pop     = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !pop) begin
        count <= count + CW'(1);
      end else if (!wr_en && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= CW'(DEPTH));
    end
  end

endmodule

// File: rtl/divider_ctrl.sv
// rtl/divider_ctrl.sv - credit-protected issue/capture wrapper around the pipelined divider core
// A tag pipe tracks each issued op so the core result can be matched, checked and overridden on divide-by-zero.
module divider_ctrl
  import divider_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int M     = DIV_M,
  parameter int LAT   = div_lat(N),
  parameter int DEPTH = DIV_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_dividend,
  input  logic [M-1:0] in_divisor,
  output logic         div_data_rdy,
  output logic [N-1:0] div_dividend,
  output logic [M-1:0] div_divisor,
  input  logic         div_res_rdy,
  input  logic [N-1:0] div_merchant,
  input  logic [M-1:0] div_remainder,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_quotient,
  output logic [M-1:0] out_remainder,
  output logic         out_dbz,
  output logic         err_sync
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = $bits(div_result_t);

  // The result record layout is shared with the rest of the algorithm directory.
  if (N != DIV_N || M != DIV_M) begin : g_geom_check
    $error("divider_ctrl: N/M must match the divider_pkg result geometry");
  end
  if (LAT < 1) begin : g_lat_check
    $error("divider_ctrl: LAT must be at least 1");
  end

  logic            data_rdy_q;
  logic [N-1:0]    dividend_q;
  logic [M-1:0]    divisor_q;
  logic            err_q;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credits_used;
  logic            credit_ok;
  logic            fire;
  logic            pop;
  div_tag_t        tag_pipe [LAT+1];
  div_tag_t        head;
  div_result_t     wr_result;
  div_result_t     rd_result;
  logic [RW-1:0]   fifo_rd_data;

  // Credits cover both in-flight ops and buffered results, so the core can never overrun the FIFO.
  assign credits_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok    = credits_used < (CW+1)'(DEPTH);
  assign in_ready     = credit_ok && !rst;
  assign fire         = in_valid && in_ready;
  assign head         = tag_pipe[LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      data_rdy_q <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      inflight   <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i <= LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      data_rdy_q <= fire;
      if (fire) begin
        dividend_q <= in_dividend;
        divisor_q  <= in_divisor;
      end

      tag_pipe[0].valid <= fire;
      tag_pipe[0].dbz   <= fire && (in_divisor == '0);
      for (int i = 1; i <= LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end

      if (fire && !div_res_rdy) begin
        inflight <= inflight + CW'(1);
      end else if (!fire && div_res_rdy) begin
        inflight <= inflight - CW'(1);
      end

      if (div_res_rdy != head.valid) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    wr_result.quotient  = div_merchant;
    wr_result.remainder = div_remainder;
    wr_result.dbz       = 1'b0;
    if (head.dbz) begin
      wr_result.quotient  = DBZ_QUOTIENT;
      wr_result.remainder = '0;
      wr_result.dbz       = 1'b1;
    end
  end

  divider_result_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (div_res_rdy),
    .wr_data (wr_result),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count)
  );

  assign rd_result = fifo_rd_data;
  assign pop       = out_valid && out_ready;

  // Outputs are forced low while rst is asserted, even before the registers have cleared.
  assign out_valid     = (fifo_count != '0) && !rst;
  assign out_quotient  = out_valid ? rd_result.quotient  : '0;
  assign out_remainder = out_valid ? rd_result.remainder : '0;
  assign out_dbz       = out_valid && rd_result.dbz;

  assign div_data_rdy  = data_rdy_q && !rst;
  assign div_dividend  = rst ? '0 : dividend_q;
  assign div_divisor   = rst ? '0 : divisor_q;
  assign err_sync      = err_q && !rst;

endmodule
